// File: rtl/uart_tx_fifo_if.sv
// Word stream into the UART transmitter: the source drives data/valid, the transmitter answers with ready.
// A word moves on any rising edge where in_valid and in_ready are both high; in_valid may rise without waiting for in_ready.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO_DEPTH-word input FIFO feeding an LSB-first serialiser
// with per-frame baud divider, parity mode and stop-bit count latched when a word is popped.
module uart_tx_fifo #(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    uart_tx_fifo_if.slave   in_if,
    input  logic [31:0]     baud_div_i,
    input  logic [1:0]      parity_i,
    input  logic            stop2_i,
    output logic            tx_o,
    output logic [LW-1:0]   fifo_level_o,
    output logic            busy_o,
    output logic [2:0]      state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    logic [DATA_BITS-1:0] shreg_q;
    logic [31:0]          div_q, cnt_q;
    logic                 par_en_q, par_bit_q, stop2_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic                 period_end;
    logic                 tx_d, busy_d;

    // in_ready depends only on the registered level, so a full FIFO never overwrites.
    assign in_if.in_ready = (level_q != LW'(FIFO_DEPTH));
    assign push           = in_if.in_valid & in_if.in_ready;
    assign pop            = (state_q == S_IDLE) && (level_q != '0);
    assign head           = mem_q[rd_ptr_q];
    assign period_end     = (cnt_q == div_q);
    assign fifo_level_o   = level_q;
    assign state_o        = state_q;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (level_q != '0) state_d = S_START;
            S_START:  if (period_end) state_d = S_DATA;
            S_DATA:   if (period_end && bit_idx_q == BW'(DATA_BITS - 1))
                          state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (period_end) state_d = S_STOP;
            S_STOP:   if (period_end && stop_idx_q == stop2_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_q)
            S_IDLE:   busy_d = 1'b0;
            S_START:  tx_d   = 1'b0;
            S_DATA:   tx_d   = shreg_q[0];
            S_PARITY: tx_d   = par_bit_q;
            default:  tx_d   = 1'b1;
        endcase
    end

    assign busy_o = busy_d;

    // Frame config is captured at pop so mid-frame input changes only affect the next word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_o       <= 1'b1;
        end else begin
            tx_o <= tx_d;
            if (pop) begin
                shreg_q   <= head;
                div_q     <= baud_div_i;
                par_en_q  <= (parity_i == 2'b01) || (parity_i == 2'b10);
                par_bit_q <= (parity_i == 2'b01) ? ~(^head) : (^head);
                stop2_q   <= stop2_i;
            end
            // Bit timer restarts on every state entry and at each period end.
            if (state_q == S_IDLE || state_d != state_q || period_end) cnt_q <= '0;
            else                                                        cnt_q <= cnt_q + 32'd1;
            if (state_q == S_START) bit_idx_q <= '0;
            if (state_q == S_DATA && period_end) begin
                shreg_q   <= {1'b0, shreg_q[DATA_BITS-1:1]};
                bit_idx_q <= bit_idx_q + BW'(1);
            end
            if (state_q != S_STOP)    stop_idx_q <= 1'b0;
            else if (period_end)      stop_idx_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized bursts, with a line monitor that
// rebuilds each expected frame from its word and latched config and checks tx_o cycle by cycle.
module tb_uart_tx_fifo;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] baud_div;
    logic [1:0]  parity;
    logic        stop2;
    logic        tx8, tx9, busy8, busy9;
    logic [2:0]  lvl8, lvl9, st8, st9;

    always #5 clk_i = ~clk_i;

    uart_tx_fifo_if #(.DATA_BITS(8)) bus8 ();
    uart_tx_fifo_if #(.DATA_BITS(9)) bus9 ();

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .in_if(bus8), .baud_div_i(baud_div),
        .parity_i(parity), .stop2_i(stop2), .tx_o(tx8), .fifo_level_o(lvl8),
        .busy_o(busy8), .state_o(st8)
    );

    uart_tx_fifo #(.DATA_BITS(9), .FIFO_DEPTH(4)) dut9 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .in_if(bus9), .baud_div_i(baud_div),
        .parity_i(parity), .stop2_i(stop2), .tx_o(tx9), .fifo_level_o(lvl9),
        .busy_o(busy9), .state_o(st9)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_push_cyc = 0;
    logic [31:0] exp_q[$];
    int          start_q[$];
    bit          mon_en = 1'b1;
    bit          mon_busy = 1'b0;
    logic        prev8 = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int which);
        return (which == 1) ? tx9 : tx8;
    endfunction

    // Record layout: data[8:0], div[16:9], parity[18:17], stop2[19].
    function automatic logic [31:0] mkrec(input logic [8:0] d);
        return {12'd0, stop2, parity, baud_div[7:0], d};
    endfunction

    // Called on the negedge where the start bit is first seen low.
    task automatic rx_check(input int which, input int nbits, input logic [31:0] rec);
        logic [8:0] d;
        logic [1:0] par;
        logic       st2;
        int         div;
        int         ones;
        logic       exp_bits[$];
        d    = rec[8:0];
        div  = int'(rec[16:9]);
        par  = rec[18:17];
        st2  = rec[19];
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'b01)      exp_bits.push_back((ones % 2) == 0);
        else if (par == 2'b10) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
        if (st2) exp_bits.push_back(1'b1);
        for (int b = 0; b < exp_bits.size(); b++) begin
            for (int s = 0; s <= div; s++) begin
                if (b != 0 || s != 0) begin
                    @(negedge clk_i);
                    if (which == 0 && !mon_en) return;
                end
                check_eq($sformatf("%s_bit%0d", (which == 1) ? "tx9" : "tx8", b),
                         32'(line(which)), 32'(exp_bits[b]));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_en && prev8 === 1'b1 && tx8 === 1'b0) begin
                start_q.push_back(cyc);
                mon_busy = 1'b1;
                if (exp_q.size() == 0) check_eq("unexpected_frame", 32'(exp_q.size()), 32'd1);
                else                   rx_check(0, 8, exp_q.pop_front());
                mon_busy = 1'b0;
            end
            prev8 = tx8;
        end
    end

    task automatic push8(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk_i);
        bus8.in_data  = d;
        bus8.in_valid = 1'b1;
        while (bus8.in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) check_eq("push_ready_timeout", 32'(n), 32'd0);
        else begin
            @(posedge clk_i);
            exp_q.push_back(mkrec({1'b0, d}));
        end
        @(negedge clk_i);
        bus8.in_valid = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy8 !== 1'b0) && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_drain_timeout"}, 32'(n >= 5000), 32'd0);
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] r1, r2;
        logic [7:0]  w[8];
        int          accepts, n, lows, nw;
        logic        rdy;

        rst_n_i       = 1'b0;
        baud_div      = 32'd3;
        parity        = 2'b00;
        stop2         = 1'b0;
        bus8.in_data  = '0;
        bus8.in_valid = 1'b0;
        bus9.in_data  = '0;
        bus9.in_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_tx", 32'(tx8), 32'd1);
        check_eq("rst_ready", 32'(bus8.in_ready), 32'd1);
        check_eq("rst_level", 32'(lvl8), 32'd0);
        check_eq("rst_busy", 32'(busy8), 32'd0);
        check_eq("rst_tx9", 32'(tx9), 32'd1);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // 8N1 at div 3: latency, bit pattern, busy fall.
        start_q.delete();
        push8(8'hA5);
        repeat (2) @(negedge clk_i);
        check_eq("t1_busy_mid", 32'(busy8), 32'd1);
        check_eq("t1_level_mid", 32'(lvl8), 32'd0);
        wait_drain("t1");
        check_eq("t1_starts", 32'(start_q.size()), 32'd1);
        if (start_q.size() >= 1) check_eq("t1_latency", 32'(start_q[0] - last_push_cyc), 32'd2);
        check_eq("t1_busy_end", 32'(busy8), 32'd0);

        // Odd then even parity on 0x07, back to back at div 1.
        baud_div = 32'd1;
        parity   = 2'b01;
        start_q.delete();
        push8(8'h07);
        repeat (3) @(negedge clk_i);
        parity = 2'b10;
        push8(8'h07);
        wait_drain("t2");
        check_eq("t2_starts", 32'(start_q.size()), 32'd2);
        if (start_q.size() >= 2) check_eq("t2_interval", 32'(start_q[1] - start_q[0]), 32'd23);

        // Config change mid-frame only affects the following frame.
        baud_div = 32'd3;
        parity   = 2'b00;
        start_q.delete();
        push8(8'h3C);
        repeat (5) @(negedge clk_i);
        baud_div = 32'd7;
        parity   = 2'b10;
        push8(8'hC3);
        wait_drain("t5");
        check_eq("t5_starts", 32'(start_q.size()), 32'd2);
        if (start_q.size() >= 2) check_eq("t5_interval", 32'(start_q[1] - start_q[0]), 32'd41);

        // Nine data bits, two stop bits, back-to-back frames on the 9-bit instance.
        baud_div = 32'd1;
        parity   = 2'b00;
        stop2    = 1'b1;
        r1 = mkrec(9'h1FF);
        r2 = mkrec(9'h0AA);
        @(negedge clk_i);
        bus9.in_data  = 9'h1FF;
        bus9.in_valid = 1'b1;
        @(negedge clk_i);
        bus9.in_data  = 9'h0AA;
        @(negedge clk_i);
        bus9.in_valid = 1'b0;
        n = 0;
        while (tx9 !== 1'b0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("t3_start_timeout", 32'(n >= 100), 32'd0);
        rx_check(1, 9, r1);
        @(negedge clk_i);
        check_eq("t3_gap", 32'(tx9), 32'd1);
        @(negedge clk_i);
        check_eq("t3_start2", 32'(tx9), 32'd0);
        rx_check(1, 9, r2);
        repeat (2) @(negedge clk_i);
        check_eq("t3_level", 32'(lvl9), 32'd0);
        check_eq("t3_busy", 32'(busy9), 32'd0);
        stop2 = 1'b0;

        // Randomized bursts with constant config per burst.
        for (int r = 0; r < 8; r++) begin
            baud_div = 32'($urandom_range(0, 3));
            parity   = 2'($urandom_range(0, 3));
            stop2    = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) push8(8'($urandom_range(0, 255)));
            wait_drain("rnd");
        end

        // Hold valid at div 0: five words accepted, FIFO full at level 4.
        baud_div = 32'd0;
        parity   = 2'b00;
        stop2    = 1'b0;
        start_q.delete();
        for (int k = 0; k < 8; k++) w[k] = 8'($urandom_range(0, 255));
        accepts = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            bus8.in_valid = 1'b1;
            bus8.in_data  = w[accepts];
            rdy = bus8.in_ready;
            @(posedge clk_i);
            if (rdy === 1'b1) begin
                exp_q.push_back(mkrec({1'b0, w[accepts]}));
                accepts++;
            end
        end
        @(negedge clk_i);
        bus8.in_valid = 1'b0;
        check_eq("t4_accepts", 32'(accepts), 32'd5);
        check_eq("t4_level_full", 32'(lvl8), 32'd4);
        check_eq("t4_ready_full", 32'(bus8.in_ready), 32'd0);
        wait_drain("t4");
        check_eq("t4_starts", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < start_q.size(); i++)
            check_eq($sformatf("t4_interval%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd11);

        // Reset during DATA with two words buffered.
        baud_div = 32'd3;
        push8(8'h81);
        push8(8'h42);
        push8(8'h24);
        repeat (8) @(negedge clk_i);
        check_eq("t6_level_pre", 32'(lvl8), 32'd2);
        check_eq("t6_busy_pre", 32'(busy8), 32'd1);
        mon_en = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("t6_tx", 32'(tx8), 32'd1);
        check_eq("t6_level", 32'(lvl8), 32'd0);
        check_eq("t6_ready", 32'(bus8.in_ready), 32'd1);
        check_eq("t6_busy", 32'(busy8), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (tx8 !== 1'b1) lows++;
        end
        check_eq("t6_no_frames", 32'(lows), 32'd0);
        check_eq("t6_busy_after", 32'(busy8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
